i2c_slave_controller: RTL and testbench

I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_bus_monitor.sv | 68 ++++++
 rtl/i2c_slave_controller.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_slave_controller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared definitions for the I2C slave controller: controller
//                state encoding plus the ACK/NACK and R/W bit values as they
//                appear on the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  // Level of SDA during the acknowledge bit
  localparam logic c_ack      = 1'b0;
  localparam logic c_nack     = 1'b1;

  // Least significant bit of the address byte
  localparam logic c_rw_write = 1'b0;
  localparam logic c_rw_read  = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_monitor
//  Description : Brings the raw SCL/SDA lines into the clock domain with a
//                two-flop synchronizer and decodes bus events as registered
//                one-cycle pulses (three clocks after the pin edge).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock     in   system clock
//    reset     in   asynchronous active-high reset
//    scl, sda  in   raw bus lines
//    start     out  SDA fell while SCL high
//    stop      out  SDA rose while SCL high
//    scl_rise  out  SCL rising edge
//    scl_fall  out  SCL falling edge
//    sda_level out  synchronized SDA, aligned with the event pulses
// ============================================================================
module i2c_bus_monitor (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_level
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl;
  logic       w_sda;

  assign w_scl     = r_scl_sync[1];
  assign w_sda     = r_sda_sync[1];
  assign sda_level = r_sda_prev;

  // Flops reset to 1 so that coming out of reset looks like an idle bus.
  // Start/stop also require SCL to have been high on the previous sample,
  // so SCL and SDA falling together (e.g. just after reset) is not a start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      start      <= 1'b0;
      stop       <= 1'b0;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      start      <=  r_sda_prev & ~w_sda & w_scl & r_scl_prev;
      stop       <= ~r_sda_prev &  w_sda & w_scl & r_scl_prev;
      scl_rise   <= ~r_scl_prev &  w_scl;
      scl_fall   <=  r_scl_prev & ~w_scl;
    end
  end

endmodule : i2c_bus_monitor
`default_nettype wire

// File: rtl/i2c_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_controller
//  Description : I2C slave protocol controller. Bit-level shifting is done by
//                external byte reader/writer engines; this block sequences
//                address match, acknowledge slots, byte hand-off and bus
//                events (start, repeated start, stop).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clock, reset            system clock, asynchronous active-high reset
//    scl, sda                raw bus lines
//    sda_oe                  1 = pull SDA low (slave ACK)
//    rd_go                   byte-reader request, held until finish/error
//    rd_load, rd_data        reader bit strobe and bit value, MSB first
//    rd_finish, rd_error     reader completion / abort pulses
//    wr_go, wr_byte          byte-writer request and byte to shift out
//    wr_finish, wr_error     writer completion / abort pulses
//    rx_data, rx_valid       received data byte and its strobe
//    tx_data, tx_req         byte to transmit, sampled while tx_req = 1
//    busy                    addressed and active
//    error                   one-cycle error pulse
// ============================================================================
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_oe,
  output logic       rd_go,
  input  logic       rd_load,
  input  logic       rd_data,
  input  logic       rd_finish,
  input  logic       rd_error,
  output logic       wr_go,
  output logic [7:0] wr_byte,
  input  logic       wr_finish,
  input  logic       wr_error,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       error
);

  logic       w_start;
  logic       w_stop;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_sda_level;

  i2c_state_e r_state;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_ack_on;   // ACK currently driven in an ACK slot

  i2c_bus_monitor u_bus_monitor (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .start     (w_start),
    .stop      (w_stop),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .sda_level (w_sda_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_shift  <= 8'h00;
      r_rw     <= 1'b0;
      r_ack_on <= 1'b0;
      sda_oe   <= 1'b0;
      rd_go    <= 1'b0;
      wr_go    <= 1'b0;
      wr_byte  <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      error    <= 1'b0;

      // Bus events take priority over anything the engines report
      if (w_stop) begin
        r_state  <= ST_IDLE;
        rd_go    <= 1'b0;
        wr_go    <= 1'b0;
        sda_oe   <= 1'b0;
        r_ack_on <= 1'b0;
        busy     <= 1'b0;
      end else if (w_start && (r_state != ST_IDLE)) begin
        r_state  <= ST_ADDR;
        rd_go    <= 1'b0;
        wr_go    <= 1'b0;
        sda_oe   <= 1'b0;
        r_ack_on <= 1'b0;
        r_shift  <= 8'h00;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state <= ST_ADDR;
              r_shift <= 8'h00;
            end
          end

          // rd_go is raised one cycle after entry, so engine strobes are
          // only honoured while the request is actually outstanding.
          ST_ADDR, ST_RX_BYTE: begin
            if (rd_go && rd_error) begin
              rd_go   <= 1'b0;
              error   <= 1'b1;
              busy    <= 1'b0;
              r_state <= ST_WAIT_STOP;
            end else if (rd_go && rd_finish) begin
              rd_go <= 1'b0;
              if (r_state == ST_RX_BYTE) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
                r_ack_on <= 1'b0;
                r_state  <= ST_RX_ACK;
              end else if (r_shift[7:1] == SLAVE_ADDR) begin
                busy     <= 1'b1;
                r_rw     <= r_shift[0];
                r_ack_on <= 1'b0;
                r_state  <= ST_ADDR_ACK;
              end else begin
                busy    <= 1'b0;
                r_state <= ST_WAIT_STOP;
              end
            end else begin
              rd_go <= 1'b1;
              if (rd_go && rd_load) begin
                r_shift <= {r_shift[6:0], rd_data};
              end
            end
          end

          // ACK is driven from the first SCL fall to the next one; the
          // release edge is also where the next byte phase begins.
          ST_ADDR_ACK, ST_RX_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                sda_oe   <= 1'b1;
                r_ack_on <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                r_ack_on <= 1'b0;
                if ((r_state == ST_ADDR_ACK) && (r_rw == c_rw_read)) begin
                  tx_req  <= 1'b1;
                  r_state <= ST_TX_BYTE;
                end else begin
                  r_shift <= 8'h00;
                  r_state <= ST_RX_BYTE;
                end
              end
            end
          end

          // tx_req is high in the first cycle here: capture the byte then
          // and only afterwards start the writer, so wr_byte is stable.
          ST_TX_BYTE: begin
            if (tx_req) begin
              wr_byte <= tx_data;
              wr_go   <= 1'b1;
            end else if (wr_go && wr_error) begin
              wr_go   <= 1'b0;
              error   <= 1'b1;
              busy    <= 1'b0;
              r_state <= ST_WAIT_STOP;
            end else if (wr_go && wr_finish) begin
              wr_go   <= 1'b0;
              r_state <= ST_TX_ACK;
            end
          end

          ST_TX_ACK: begin
            if (w_scl_rise) begin
              if (w_sda_level == c_ack) begin
                tx_req  <= 1'b1;
                r_state <= ST_TX_BYTE;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end

          ST_WAIT_STOP: begin
            r_state <= ST_WAIT_STOP;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : i2c_slave_controller
`default_nettype wire

// File: tb/tb_i2c_slave_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave_controller
//  Description : Self-checking bench for i2c_slave_controller. The bench plays
//                bus master (SCL/SDA pins, wired-AND with the slave ACK) and
//                the byte reader/writer engines, and derives expected ACKs,
//                received bytes, tx requests and errors from transaction
//                level rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_controller;

  localparam logic [6:0] SLAVE = 7'h50;

  logic       clock;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       rd_go;
  logic       rd_load;
  logic       rd_data;
  logic       rd_finish;
  logic       rd_error;
  logic       wr_go;
  logic [7:0] wr_byte;
  logic       wr_finish;
  logic       wr_error;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       error;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_controller #(.SLAVE_ADDR(SLAVE)) dut (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl_m),
    .sda       (sda_line),
    .sda_oe    (sda_oe),
    .rd_go     (rd_go),
    .rd_load   (rd_load),
    .rd_data   (rd_data),
    .rd_finish (rd_finish),
    .rd_error  (rd_error),
    .wr_go     (wr_go),
    .wr_byte   (wr_byte),
    .wr_finish (wr_finish),
    .wr_error  (wr_error),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] rx_q[$];
  int         tx_cnt = 0;
  int         err_cnt = 0;
  int         ack_cnt = 0;
  int         both_cnt = 0;
  logic       oe_prev = 1'b0;
  logic [7:0] pat [0:3];

  // Event observers, sampled mid-cycle
  always @(negedge clock) begin
    if (rx_valid)        rx_q.push_back(rx_data);
    if (tx_req)          tx_cnt++;
    if (error)           err_cnt++;
    if (sda_oe && !oe_prev) ack_cnt++;
    if (rd_go && wr_go)  both_cnt++;
    oe_prev = sda_oe;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_scl(input logic v);
    scl_m = v;
    wait_cyc(6);
  endtask

  task automatic set_sda(input logic v);
    sda_m = v;
    wait_cyc(6);
  endtask

  task automatic bus_start();
    set_sda(1'b0);
  endtask

  task automatic bus_rep_start();
    set_scl(1'b0);
    set_sda(1'b1);
    set_scl(1'b1);
    set_sda(1'b0);
  endtask

  task automatic bus_stop();
    set_scl(1'b0);
    set_sda(1'b0);
    set_scl(1'b1);
    set_sda(1'b1);
  endtask

  task automatic wait_go(input bit rd, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if ((rd ? rd_go : wr_go) == 1'b1) begin
        ok = 1'b1;
        break;
      end
      wait_cyc(1);
    end
    if (!ok) check_value(rd ? "rd_go_timeout" : "wr_go_timeout", 0, 1);
  endtask

  // Reader engine: deliver b MSB first, or abort part-way with rd_error
  task automatic reader(input logic [7:0] b, input bit err);
    bit ok;
    int stop_at;
    wait_go(1'b1, ok);
    if (!ok) return;
    stop_at = err ? int'($urandom_range(0, 7)) : 8;
    for (int i = 0; i < stop_at; i++) begin
      rd_load = 1'b1;
      rd_data = b[7 - i];
      wait_cyc(1);
      rd_load = 1'b0;
      rd_data = 1'b0;
      wait_cyc(1);
    end
    if (err) begin
      rd_error = 1'b1;
      wait_cyc(1);
      rd_error = 1'b0;
      check_value("rd_go_after_error", rd_go, 0);
      check_value("error_pulse", error, 1);
      wait_cyc(1);
      check_value("error_one_cycle", error, 0);
    end else begin
      rd_finish = 1'b1;
      wait_cyc(1);
      rd_finish = 1'b0;
      check_value("rd_go_after_finish", rd_go, 0);
    end
  endtask

  // Writer engine: check the offered byte, then finish or abort
  task automatic writer(input logic [7:0] exp, input bit err);
    bit ok;
    wait_go(1'b0, ok);
    if (!ok) return;
    check_value("wr_byte", wr_byte, exp);
    check_value("rd_go_during_wr", rd_go, 0);
    tx_data = 8'($urandom);
    wait_cyc(4);
    check_value("wr_byte_stable", wr_byte, exp);
    if (err) begin
      wr_error = 1'b1;
      wait_cyc(1);
      wr_error = 1'b0;
      check_value("wr_go_after_error", wr_go, 0);
      check_value("wr_error_pulse", error, 1);
      wait_cyc(1);
    end else begin
      wr_finish = 1'b1;
      wait_cyc(1);
      wr_finish = 1'b0;
      check_value("wr_go_after_finish", wr_go, 0);
    end
  endtask

  // Ninth clock of a master-to-slave byte; slave should ACK iff exp
  task automatic ack_slot(input logic exp);
    set_scl(1'b0);
    check_value("ack_slot_low", sda_oe, exp);
    set_scl(1'b1);
    check_value("ack_slot_high", sda_oe, exp);
    set_scl(1'b0);
    check_value("ack_released", sda_oe, 0);
    set_scl(1'b1);
  endtask

  // Ninth clock of a slave-to-master byte; master drives ACK or NACK
  task automatic master_ack(input bit ack);
    set_scl(1'b0);
    set_sda(ack ? 1'b0 : 1'b1);
    set_scl(1'b1);
  endtask

  // One transaction. err_at: -1 none, 0 address byte, k data byte k-1.
  task automatic run_txn(input logic [6:0] addr, input bit rw, input int n,
                         input int err_at, input bit rstart, input bit end_stop);
    bit         hit;
    bit         dead;
    int         exp_ack;
    int         exp_tx;
    int         exp_err;
    logic [7:0] exp_rx[$];
    hit     = (addr == SLAVE);
    dead    = 1'b0;
    exp_ack = 0;
    exp_tx  = 0;
    exp_err = 0;
    rx_q.delete();
    tx_cnt  = 0;
    err_cnt = 0;
    ack_cnt = 0;

    if (rstart) bus_rep_start();
    else        bus_start();

    if (err_at == 0) begin
      reader({addr, rw}, 1'b1);
      exp_err = 1;
      dead    = 1'b1;
    end else begin
      reader({addr, rw}, 1'b0);
      if (!hit) begin
        if (!rstart) check_value("busy_no_match", busy, 0);
        ack_slot(1'b0);
        check_value("no_match_rd_go", rd_go, 0);
        check_value("no_match_wr_go", wr_go, 0);
        dead = 1'b1;
      end else begin
        check_value("busy_on_match", busy, 1);
        exp_ack++;
        if (rw) begin
          tx_data = pat[0];
          exp_tx  = 1;
        end
        ack_slot(1'b1);
      end
    end

    if (!dead && !rw) begin
      for (int k = 0; k < n; k++) begin
        if (err_at == k + 1) begin
          reader(pat[k], 1'b1);
          exp_err = 1;
          break;
        end
        reader(pat[k], 1'b0);
        exp_rx.push_back(pat[k]);
        exp_ack++;
        ack_slot(1'b1);
      end
    end else if (!dead && rw) begin
      for (int k = 0; k < n; k++) begin
        if (err_at == k + 1) begin
          writer(pat[k], 1'b1);
          exp_err = 1;
          break;
        end
        writer(pat[k], 1'b0);
        if (k < n - 1) begin
          tx_data = pat[k + 1];
          exp_tx++;
          master_ack(1'b1);
        end else begin
          master_ack(1'b0);
        end
      end
    end

    if (end_stop) begin
      bus_stop();
      check_value("busy_after_stop", busy, 0);
      check_value("sda_oe_after_stop", sda_oe, 0);
      check_value("wr_go_after_stop", wr_go, 0);
      wait_cyc(4);
      check_value("rd_go_idle", rd_go, 0);
    end

    check_value("ack_count", ack_cnt, exp_ack);
    check_value("tx_req_count", tx_cnt, exp_tx);
    check_value("error_count", err_cnt, exp_err);
    check_value("rx_count", rx_q.size(), exp_rx.size());
    foreach (exp_rx[i]) begin
      if (i < rx_q.size()) check_value("rx_data", rx_q[i], exp_rx[i]);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_value({pfx, "_sda_oe"},   sda_oe,   0);
    check_value({pfx, "_rd_go"},    rd_go,    0);
    check_value({pfx, "_wr_go"},    wr_go,    0);
    check_value({pfx, "_tx_req"},   tx_req,   0);
    check_value({pfx, "_rx_valid"}, rx_valid, 0);
    check_value({pfx, "_busy"},     busy,     0);
    check_value({pfx, "_error"},    error,    0);
    check_value({pfx, "_rx_data"},  rx_data,  0);
    check_value({pfx, "_wr_byte"},  wr_byte,  0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    rd_load   = 1'b0;
    rd_data   = 1'b0;
    rd_finish = 1'b0;
    rd_error  = 1'b0;
    wr_finish = 1'b0;
    wr_error  = 1'b0;
    tx_data   = 8'h00;
    wait_cyc(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_cyc(5);

    // Write 0x3C to our address
    pat[0] = 8'h3C;
    run_txn(SLAVE, 1'b0, 1, -1, 1'b0, 1'b1);

    // Foreign address 0x51
    pat[0] = 8'h77;
    run_txn(7'h51, 1'b0, 1, -1, 1'b0, 1'b1);

    // Read 0x5A, 0xC3 with ACK then NACK
    pat[0] = 8'h5A;
    pat[1] = 8'hC3;
    run_txn(SLAVE, 1'b1, 2, -1, 1'b0, 1'b1);

    // Write 0x11, repeated start, then read one byte
    pat[0] = 8'h11;
    run_txn(SLAVE, 1'b0, 1, -1, 1'b0, 1'b0);
    pat[0] = 8'hE4;
    run_txn(SLAVE, 1'b1, 1, -1, 1'b1, 1'b1);

    // Reader abort in the first data byte
    pat[0] = 8'h99;
    run_txn(SLAVE, 1'b0, 2, 1, 1'b0, 1'b1);

    // Reset while the ACK is being driven
    bus_start();
    reader({SLAVE, 1'b0}, 1'b0);
    set_scl(1'b0);
    check_value("ack_before_reset", sda_oe, 1);
    #2 reset = 1'b1;
    #1 check_value("reset_async_sda_oe", sda_oe, 0);
    check_reset_outputs("midreset");
    wait_cyc(2);
    reset = 1'b0;
    set_scl(1'b1);
    set_sda(1'b1);
    check_value("post_reset_rd_go", rd_go, 0);

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      logic [6:0] a;
      bit         rw;
      int         n;
      int         e;
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) a = SLAVE;
      rw = 1'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 3));
      e  = -1;
      if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, n));
      for (int k = 0; k < 4; k++) pat[k] = 8'($urandom);
      run_txn(a, rw, n, e, 1'b0, 1'b1);
    end

    check_value("rd_wr_go_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_i2c_slave_controller
`default_nettype wire
